lfsr_rng: RTL

- Parametrised XNOR Fibonacci LFSR: the pseudo-random source for CPU-player and game-timing logic.
- Generalises the fixed 10-bit generator in four ways:
  - Width is selectable; the maximal-length tap set comes from a shared table.
  - It supports enable-gated stepping and synchronous seed load.
  - It recovers automatically from the XNOR lockup state.
  - It reports sequence wrap-around and gives a threshold "fire" output that drives CPU button presses.

---
 rtl/lfsr_pkg.sv | 30 +++
 rtl/lfsr_rng.sv | 76 +++++++
 2 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: legal width range and maximal-length XNOR tap table.
package lfsr_pkg;

  localparam int LFSR_MIN_W = 3;
  localparam int LFSR_MAX_W = 16;

  // Bit i set means state bit i feeds the XNOR; the all-ones state is the lockup state.
  function automatic logic [15:0] tap_mask(input int width);
    logic [15:0] m;
    case (width)
      3:       m = 16'h0006;
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lfsr_rng.sv
// XNOR Fibonacci LFSR with seed load, lockup recovery, wrap detection and threshold fire.
module lfsr_rng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 10,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] threshold,
  output logic [WIDTH-1:0] out,
  output logic             fire,
  output logic             wrapped,
  output logic             lockup,
  output logic [WIDTH-1:0] steps
);

  if (WIDTH < LFSR_MIN_W || WIDTH > LFSR_MAX_W) begin : g_bad_width
    $error("lfsr_rng: WIDTH must be within 3..16");
  end
  if (RESET_VAL == {WIDTH{1'b1}}) begin : g_bad_reset
    $error("lfsr_rng: RESET_VAL must not be the all-ones lockup state");
  end

  localparam logic [15:0]      MASK = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS = MASK[WIDTH-1:0];

  logic [WIDTH-1:0] start_p0;
  logic [WIDTH-1:0] nxt;
  logic             fb;
  logic             all_ones;

  always_comb begin
    fb       = ~^(out & TAPS);
    nxt      = {out[WIDTH-2:0], fb};
    all_ones = &out;
    fire     = out > threshold;
  end

  // Register stage: state, start marker, step counter and event pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      out      <= RESET_VAL;
      start_p0 <= RESET_VAL;
      steps    <= '0;
      wrapped  <= 1'b0;
      lockup   <= 1'b0;
    end else begin
      wrapped <= 1'b0;
      lockup  <= 1'b0;
      if (load) begin
        out      <= seed;
        start_p0 <= seed;
        steps    <= '0;
      end else if (all_ones) begin
        // XNOR feedback would hold all-ones forever; restart from zero instead.
        out      <= '0;
        start_p0 <= '0;
        steps    <= '0;
        lockup   <= 1'b1;
      end else if (en) begin
        out <= nxt;
        if (nxt == start_p0) begin
          steps   <= '0;
          wrapped <= 1'b1;
        end else begin
          steps <= steps + WIDTH'(1);
        end
      end
    end
  end

endmodule
